// File: rtl/display_pkg.sv
// Shared 7-segment constants and helpers for the display scanners.
// Segment order is {g,f,e,d,c,b,a}, active-low.
package display_pkg;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   function automatic logic [6:0] digit_to_seg(input logic [3:0] d);
      case (d)
         4'd0:    digit_to_seg = SEG_0;
         4'd1:    digit_to_seg = SEG_1;
         4'd2:    digit_to_seg = SEG_2;
         4'd3:    digit_to_seg = SEG_3;
         4'd4:    digit_to_seg = SEG_4;
         4'd5:    digit_to_seg = SEG_5;
         4'd6:    digit_to_seg = SEG_6;
         4'd7:    digit_to_seg = SEG_7;
         4'd8:    digit_to_seg = SEG_8;
         4'd9:    digit_to_seg = SEG_9;
         default: digit_to_seg = SEG_BLANK;
      endcase
   endfunction

   // Largest value representable in the given number of decimal digits.
   function automatic logic [63:0] max_decimal(input int unsigned digits);
      logic [63:0] p;
      p = 64'd1;
      for (int unsigned i = 0; i < digits; i++)
         p = p * 64'd10;
      return p - 64'd1;
   endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter with change detection.
// Result on bcd is valid in the cycle done is high.
module bin_to_bcd_seq
   import display_pkg::*;
#(
   parameter int unsigned VALUE_W    = 14,
   parameter int unsigned NUM_DIGITS = 4
)
(
   input  logic                    clk,
   input  logic                    arst,
   input  logic                    start,
   input  logic [VALUE_W-1:0]      bin,
   output logic [4*NUM_DIGITS-1:0] bcd,
   output logic                    done,
   output logic                    busy,
   output logic                    overflow
);

   localparam int unsigned BCD_W   = 4 * NUM_DIGITS;
   localparam int unsigned CNT_W   = $clog2(VALUE_W + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(VALUE_W - 1);
   localparam logic [63:0] MAX_VAL = max_decimal(NUM_DIGITS);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] SHIFT = 1'b1;

   logic [0:0]         state;
   logic [VALUE_W-1:0] snap;
   logic [VALUE_W-1:0] sr;
   logic [BCD_W-1:0]   acc;
   logic [BCD_W-1:0]   acc_adj;
   logic [BCD_W-1:0]   acc_next;
   logic [CNT_W-1:0]   cnt;

   always_comb begin
      acc_adj = acc;
      for (int unsigned i = 0; i < NUM_DIGITS; i++)
         if (acc[4*i +: 4] >= 4'd5)
            acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
      acc_next = {acc_adj[BCD_W-2:0], sr[VALUE_W-1]};
   end

   assign bcd  = acc_next;
   assign done = (state == SHIFT) && (cnt == LAST);
   assign busy = (state == SHIFT);

   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         state    <= IDLE;
         snap     <= '0;
         sr       <= '0;
         acc      <= '0;
         cnt      <= '0;
         overflow <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start && (bin != snap)) begin
                  snap  <= bin;
                  sr    <= bin;
                  acc   <= '0;
                  cnt   <= '0;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               acc <= acc_next;
               sr  <= sr << 1;
               if (cnt == LAST) begin
                  overflow <= (64'(snap) > MAX_VAL);
                  state    <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/seg_scan_display.sv
// Multi-digit 7-segment scanner: BCD conversion, leading-zero blanking,
// overflow dashes and blink, multiplexed on the display-rate tick.
module seg_scan_display
   import display_pkg::*;
#(
   parameter int unsigned NUM_DIGITS  = 4,
   parameter int unsigned VALUE_W     = 14,
   parameter int unsigned LZ_BLANK    = 1,
   parameter int unsigned BLINK_TICKS = 256
)
(
   input  logic                  clk,
   input  logic                  arst,
   input  logic                  tick,
   input  logic [VALUE_W-1:0]    value,
   input  logic                  blink,
   output logic [NUM_DIGITS-1:0] an,
   output logic [6:0]            seg,
   output logic                  busy,
   output logic                  overflow
);

   localparam int unsigned BCD_W = 4 * NUM_DIGITS;
   localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
   localparam int unsigned BLK_W = $clog2(BLINK_TICKS);

   logic [BCD_W-1:0]      conv_bcd;
   logic                  conv_done;
   logic [BCD_W-1:0]      disp;
   logic [IDX_W-1:0]      idx;
   logic [BLK_W-1:0]      blk_cnt;
   logic                  blk_phase;
   logic [3:0]            cur_nib;
   logic                  upper_zero;
   logic [6:0]            seg_next;
   logic [NUM_DIGITS-1:0] an_next;

   bin_to_bcd_seq #(
      .VALUE_W    (VALUE_W),
      .NUM_DIGITS (NUM_DIGITS)
   ) u_conv (
      .clk      (clk),
      .arst     (arst),
      .start    (1'b1),
      .bin      (value),
      .bcd      (conv_bcd),
      .done     (conv_done),
      .busy     (busy),
      .overflow (overflow)
   );

   // Decode uses the registered display word, so a conversion finishing on
   // a tick cycle only becomes visible from the following tick.
   always_comb begin
      cur_nib    = '0;
      upper_zero = 1'b1;
      an_next    = '1;
      seg_next   = SEG_BLANK;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (IDX_W'(i) == idx) begin
            cur_nib    = disp[4*i +: 4];
            an_next[i] = 1'b0;
         end
         if ((IDX_W'(i) >= idx) && (disp[4*i +: 4] != 4'd0))
            upper_zero = 1'b0;
      end
      if (overflow)
         seg_next = SEG_DASH;
      else if ((LZ_BLANK != 0) && (idx != '0) && upper_zero)
         seg_next = SEG_BLANK;
      else
         seg_next = digit_to_seg(cur_nib);
      if (blink && blk_phase)
         an_next = '1;
   end

   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         idx       <= '0;
         an        <= '1;
         seg       <= SEG_BLANK;
         disp      <= '0;
         blk_cnt   <= '0;
         blk_phase <= 1'b0;
      end else begin
         if (conv_done)
            disp <= conv_bcd;
         if (tick) begin
            an  <= an_next;
            seg <= seg_next;
            idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
         end
         if (!blink) begin
            blk_cnt   <= '0;
            blk_phase <= 1'b0;
         end else if (tick) begin
            if (blk_cnt == BLK_W'(BLINK_TICKS - 1)) begin
               blk_cnt   <= '0;
               blk_phase <= ~blk_phase;
            end else begin
               blk_cnt <= blk_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_display.sv
// Scoreboard bench for seg_scan_display: stimulus queues expected an/seg per
// tick, a monitor pops and compares after every accepted tick.
`timescale 1ns/1ps
module tb_seg_scan_display;

   localparam int unsigned ND = 4;
   localparam int unsigned VW = 14;
   localparam int unsigned BT = 4;

   localparam logic [6:0] S0 = 7'b1000000;
   localparam logic [6:0] S1 = 7'b1111001;
   localparam logic [6:0] S2 = 7'b0100100;
   localparam logic [6:0] S3 = 7'b0110000;
   localparam logic [6:0] S4 = 7'b0011001;
   localparam logic [6:0] S5 = 7'b0010010;
   localparam logic [6:0] S7 = 7'b1111000;
   localparam logic [6:0] S8 = 7'b0000000;
   localparam logic [6:0] S9 = 7'b0010000;
   localparam logic [6:0] SD = 7'b0111111;
   localparam logic [6:0] SB = 7'b1111111;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
   } exp_t;

   logic          clk = 1'b0;
   logic          arst = 1'b0;
   logic          tick = 1'b0;
   logic          blink = 1'b0;
   logic [VW-1:0] value = '0;
   logic [ND-1:0] an;
   logic [6:0]    seg;
   logic          busy;
   logic          overflow;

   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   seg_scan_display #(
      .NUM_DIGITS  (ND),
      .VALUE_W     (VW),
      .LZ_BLANK    (1),
      .BLINK_TICKS (BT)
   ) dut (
      .clk      (clk),
      .arst     (arst),
      .tick     (tick),
      .value    (value),
      .blink    (blink),
      .an       (an),
      .seg      (seg),
      .busy     (busy),
      .overflow (overflow)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every tick accepted out of reset produces one registered an/seg.
   always @(posedge clk) begin
      if (tick && arst) begin
         exp_t e;
         #1;
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scan_unexpected: got an=%b seg=%b with empty queue", an, seg);
         end else begin
            e = exp_q.pop_front();
            check("scan_an", 32'(an), 32'(e.an));
            check("scan_seg", 32'(seg), 32'(e.seg));
         end
      end
   end

   task automatic scan(input logic [3:0] a, input logic [6:0] s);
      exp_q.push_back(exp_t'{an: a, seg: s});
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_idle(input string name);
      int k;
      k = 0;
      @(negedge clk);
      while (busy && k < 200) begin
         @(negedge clk);
         k++;
      end
      check(name, 32'(busy), 32'd0);
   endtask

   task automatic scan4(input logic [6:0] s0, input logic [6:0] s1,
                        input logic [6:0] s2, input logic [6:0] s3);
      scan(4'b1110, s0);
      scan(4'b1101, s1);
      scan(4'b1011, s2);
      scan(4'b0111, s3);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      logic [6:0] s802 [4];
      s802[0] = S2; s802[1] = S0; s802[2] = S8; s802[3] = SB;

      repeat (3) @(negedge clk);
      check("rst_an", 32'(an), 32'hF);
      check("rst_seg", 32'(seg), 32'(SB));
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);
      arst = 1'b1;
      @(negedge clk);

      // value 0: digit 0 shows 0, higher digits blanked
      scan4(S0, SB, SB, SB);

      // 1234: busy for exactly VALUE_W cycles
      value = 14'd1234;
      cnt = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (busy) cnt++;
         else if (cnt > 0) break;
      end
      check("busy_len_1234", 32'(cnt), 32'd14);
      check("ovf_1234", 32'(overflow), 32'd0);
      scan4(S4, S3, S2, S1);

      value = 14'd10000;
      wait_idle("idle_10000");
      check("ovf_10000", 32'(overflow), 32'd1);
      scan4(SD, SD, SD, SD);

      value = 14'd9999;
      wait_idle("idle_9999");
      check("ovf_9999", 32'(overflow), 32'd0);
      scan4(S9, S9, S9, S9);

      // 57 then 802 arriving on the third shift cycle
      value = 14'd57;
      @(negedge clk);
      check("busy_57", 32'(busy), 32'd1);
      @(negedge clk);
      @(negedge clk);
      value = 14'd802;
      cnt = 0;
      while (busy && cnt < 100) begin
         @(negedge clk);
         cnt++;
      end
      check("first_done", 32'(busy), 32'd0);
      @(negedge clk);
      check("second_busy", 32'(busy), 32'd1);
      scan4(S7, S5, SB, SB);
      check("still_busy_802", 32'(busy), 32'd1);
      wait_idle("idle_802");
      scan4(S2, S0, S8, SB);

      // blink with 4-tick half period: lit, dark, lit
      blink = 1'b1;
      for (int t = 0; t < 12; t++) begin
         logic [3:0] a;
         a = 4'b1111;
         if ((t / 4) != 1) a[t % 4] = 1'b0;
         scan(a, s802[t % 4]);
      end
      blink = 1'b0;
      scan4(S2, S0, S8, SB);

      // reset mid-conversion with a tick pending
      value = 14'd1234;
      repeat (3) @(negedge clk);
      check("pre_rst_busy", 32'(busy), 32'd1);
      tick = 1'b1;
      arst = 1'b0;
      #1;
      check("mid_rst_an", 32'(an), 32'hF);
      check("mid_rst_seg", 32'(seg), 32'(SB));
      check("mid_rst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      tick = 1'b0;
      @(negedge clk);
      arst = 1'b1;
      @(negedge clk);
      check("reconv_busy", 32'(busy), 32'd1);
      wait_idle("idle_reconv");
      scan4(S4, S3, S2, S1);

      for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
      check("queue_drain", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
